sar_conv_ctrl: RTL



---
 rtl/sar_conv_pkg.sv | 22 ++
 rtl/sar_conv_if.sv | 26 ++
 rtl/sar_conv_fifo.sv | 66 ++++++
 rtl/sar_conv_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/sar_conv_pkg.sv
// Shared types and sizing helpers for the SAR conversion controller.
// Optional averaging build: define SAR_CONV_AVG_EN.
package sar_conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_EOC
    } state_t;

    localparam int DATA_W_DEF     = 8;
    localparam int CNVST_W_DEF    = 2;
    localparam int PERIOD_DEF     = 40;
    localparam int TIMEOUT_DEF    = 64;
    localparam int FIFO_DEPTH_DEF = 4;

    // Bits needed for a counter or pointer spanning 0..n-1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sar_conv_if.sv
// Control, SAR-core and result-stream signals of the conversion controller.
interface sar_conv_if #(
    parameter int DATA_W = 8
);
    logic              en;
    logic              err_clr;
    logic [DATA_W-1:0] sar;
    logic              eoc;
    logic              cnvst;
    logic              busy;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              overflow;
    logic              timeout;

    modport master (
        input  en, err_clr, sar, eoc, dout_ready,
        output cnvst, busy, dout, dout_valid, overflow, timeout
    );

    modport slave (
        output en, err_clr, sar, eoc, dout_ready,
        input  cnvst, busy, dout, dout_valid, overflow, timeout
    );
endinterface

// File: rtl/sar_conv_fifo.sv
// Result FIFO with a registered head; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module sar_conv_fifo
    import sar_conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_valid,
    output logic              o_full
);
    localparam int AW = cnt_w(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic          w_do_pop;
    logic          w_do_push;
    logic          w_bypass;
    logic [AW-1:0] w_rd_next;
    logic [CW-1:0] w_count_next;

    assign o_full       = (r_count == CW'(DEPTH));
    assign w_do_pop     = i_pop && (r_count != '0);
    assign w_do_push    = i_push && (!o_full || w_do_pop);
    assign w_rd_next    = r_rd_ptr + AW'(w_do_pop);
    assign w_count_next = r_count + CW'(w_do_push) - CW'(w_do_pop);
    // The incoming word becomes the head when nothing older remains.
    assign w_bypass     = w_do_push && (r_count == CW'(w_do_pop));

    // NOTE: the storage array carries no reset; the pointers and count alone
    // define which entries are valid, so clearing the data would be wasted logic.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            o_dout   <= '0;
            o_valid  <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            o_valid  <= (w_count_next != '0);
            o_dout   <= w_bypass ? i_din : r_mem[w_rd_next];
        end
    end

endmodule

// File: rtl/sar_conv_ctrl.sv
// Periodic conversion initiator for the SAR ADC core with result FIFO and
// sticky error flags. Define SAR_CONV_AVG_EN to push the mean of every 4 captures.
module sar_conv_ctrl
    import sar_conv_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int CNVST_W    = CNVST_W_DEF,
    parameter int PERIOD     = PERIOD_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input logic        clk,
    input logic        rst,
    sar_conv_if.master bus
);
    localparam int PCW = cnt_w(PERIOD);
    localparam int TCW = cnt_w((TIMEOUT > CNVST_W) ? TIMEOUT : CNVST_W);
    localparam logic [PCW-1:0] PERIOD_RELOAD = PCW'(PERIOD - 1);
    localparam logic [TCW-1:0] CNVST_LAST    = TCW'(CNVST_W - 1);
    localparam logic [TCW-1:0] TIMEOUT_LAST  = TCW'(TIMEOUT - 1);

    state_t         r_state;
    logic [PCW-1:0] r_period_cnt;
    logic [TCW-1:0] r_cnt;
    logic           r_eoc_q;
    logic           r_cnvst;
    logic           r_busy;
    logic           r_overflow;
    logic           r_timeout;

    logic              w_eoc_edge;
    logic              w_timeout_evt;
    logic              w_push;
    logic [DATA_W-1:0] w_push_data;
    logic              w_pop;
    logic              w_full;
    logic              w_ovf_evt;
    logic [DATA_W-1:0] w_dout;
    logic              w_valid;

    assign w_eoc_edge    = (r_state == WAIT_EOC) && bus.eoc && !r_eoc_q;
    assign w_timeout_evt = (r_state == WAIT_EOC) && !w_eoc_edge && (r_cnt == TIMEOUT_LAST);
    assign w_pop         = w_valid && bus.dout_ready;
    assign w_ovf_evt     = w_push && w_full && !w_pop;

`ifdef SAR_CONV_AVG_EN
    localparam int AW = DATA_W + 2;

    logic [AW-1:0] r_acc;
    logic [1:0]    r_acc_cnt;
    logic [AW-1:0] w_acc_sum;

    assign w_acc_sum   = r_acc + AW'(bus.sar);
    assign w_push      = w_eoc_edge && (r_acc_cnt == 2'd3);
    assign w_push_data = w_acc_sum[AW-1:2];

    always_ff @(posedge clk) begin
        if (rst || w_timeout_evt || w_push) begin
            r_acc     <= '0;
            r_acc_cnt <= '0;
        end else if (w_eoc_edge) begin
            r_acc     <= w_acc_sum;
            r_acc_cnt <= r_acc_cnt + 1'b1;
        end
    end
`else
    assign w_push      = w_eoc_edge;
    assign w_push_data = bus.sar;
`endif

    sar_conv_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_push_data),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_valid (w_valid),
        .o_full  (w_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_period_cnt <= '0;
            r_cnt        <= '0;
            r_eoc_q      <= 1'b0;
            r_cnvst      <= 1'b0;
            r_busy       <= 1'b0;
            r_overflow   <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_eoc_q <= bus.eoc;
            // NOTE: with non-blocking assignments the last one in the block wins,
            // so the reload on START entry below overrides this free-running decrement.
            if (r_period_cnt != '0) begin
                r_period_cnt <= r_period_cnt - 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (bus.en && (r_period_cnt == '0)) begin
                        r_state      <= START;
                        r_cnvst      <= 1'b1;
                        r_busy       <= 1'b1;
                        r_cnt        <= '0;
                        r_period_cnt <= PERIOD_RELOAD;
                    end
                end
                START: begin
                    if (r_cnt == CNVST_LAST) begin
                        r_state <= WAIT_EOC;
                        r_cnvst <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT_EOC: begin
                    if (w_eoc_edge || w_timeout_evt) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // A new error event takes precedence over a clear request.
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end else if (bus.err_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_timeout_evt) begin
                r_timeout <= 1'b1;
            end else if (bus.err_clr) begin
                r_timeout <= 1'b0;
            end
        end
    end

    assign bus.cnvst      = r_cnvst;
    assign bus.busy       = r_busy;
    assign bus.dout       = w_dout;
    assign bus.dout_valid = w_valid;
    assign bus.overflow   = r_overflow;
    assign bus.timeout    = r_timeout;

endmodule
